// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, widths and the response bundle
// produced by the execute stage.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    typedef enum logic [OPW-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            overflow;
        logic            illegal;
    } alu_resp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operation code and operands in, result and flags out.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPW-1:0]  aluoperation,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output alu_resp_t       resp
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        resp = '0;
        case (aluoperation)
            ALU_AND: resp.result = op_a & op_b;
            ALU_OR:  resp.result = op_a | op_b;
            ALU_NOR: resp.result = ~(op_a | op_b);
            ALU_ADD: begin
                resp.result   = sum;
                resp.overflow = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            end
            // B is effectively inverted for SUB, so overflow needs differing operand signs
            ALU_SUB: begin
                resp.result   = diff;
                resp.overflow = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SLT: resp.result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: resp.illegal = 1'b1;
        endcase
        resp.zero = (resp.result == '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry skid buffer between the
// decode-side and writeback-side valid/ready handshakes.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  aluoperation,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e    state;
    alu_resp_t core_resp;
    alu_resp_t out_q;
    alu_resp_t skid_q;
    logic      skid_valid;
    logic      accept;

    alu_core u_core (
        .aluoperation (aluoperation),
        .op_a         (op_a),
        .op_b         (op_b),
        .resp         (core_resp)
    );

    // in_ready comes only from registered state so out_ready never reaches it
    assign skid_valid = (state == S_TWO);
    assign in_ready   = ~rst & ~skid_valid;
    assign accept     = in_valid & in_ready;

    assign out_valid = (state != S_EMPTY);
    assign result    = out_q.result;
    assign zero      = out_q.zero;
    assign overflow  = out_q.overflow;
    assign illegal   = out_q.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_q <= core_resp;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && out_ready) begin
                        out_q <= core_resp;
                    end else if (accept) begin
                        skid_q <= core_resp;
                        state  <= S_TWO;
                    end else if (out_ready) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_ready) begin
                        out_q <= skid_q;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios then random traffic, all
// compared against a queue-based reference model with plain arithmetic.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  aluoperation;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            overflow;
    logic            illegal;

    int checks = 0;
    int errors = 0;
    alu_resp_t q[$];

    alu_exec_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aluoperation (aluoperation),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .overflow     (overflow),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    function automatic alu_resp_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_resp_t r;
        longint sa;
        longint sb;
        longint full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (op)
            4'd0:  r.result = a & b;
            4'd1:  r.result = a | b;
            4'd12: r.result = ~(a | b);
            4'd2: begin
                full       = sa + sb;
                r.result   = a + b;
                r.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'd6: begin
                full       = sa - sb;
                r.result   = a - b;
                r.overflow = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'd7:  r.result = (sa < sb) ? 32'd1 : 32'd0;
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < 2)});
        if (q.size() > 0) begin
            chk("result", result, q[0].result);
            chk("zero", {31'd0, zero}, {31'd0, q[0].zero});
            chk("overflow", {31'd0, overflow}, {31'd0, q[0].overflow});
            chk("illegal", {31'd0, illegal}, {31'd0, q[0].illegal});
        end
    endtask

    // one clock: model update mirrors the handshake rules, outputs checked at negedge
    task automatic tick();
        bit acc;
        bit pop;
        alu_resp_t nr;
        acc = in_valid && !rst && (q.size() < 2);
        pop = out_ready && (q.size() > 0);
        nr  = ref_alu(aluoperation, op_a, op_b);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(nr);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; aluoperation = op; op_a = a; op_b = b;
    endtask

    initial begin
        logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5+7 with out_ready high
        out_ready = 1'b1;
        drive(1, 4'd2, 32'd5, 32'd7); tick();
        chk("add_res", result, 32'd12);
        chk("add_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        drive(1, 4'd6, 32'h8000_0000, 32'd1); tick();
        chk("sub_ovf_res", result, 32'h7FFF_FFFF);
        chk("sub_ovf", {31'd0, overflow}, 32'd1);
        drive(1, 4'd6, 32'd9, 32'd9); tick();
        chk("sub_zero_res", result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        drive(1, 4'b0101, 32'd3, 32'd4); tick();
        chk("illegal", {31'd0, illegal}, 32'd1);
        chk("illegal_zero", {31'd0, zero}, 32'd1);
        drive(0, 4'd0, 32'd0, 32'd0); tick();

        // back-pressure: two accepts fill the stage, order must survive release
        out_ready = 1'b0;
        drive(1, 4'd0, 32'h0000_F0F0, 32'h0000_0FF0); tick();
        drive(1, 4'd1, 32'h0000_F000, 32'h0000_000F); tick();
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd0);
        chk("b2b_head", result, 32'h0000_00F0);
        drive(1, 4'd7, 32'hFFFF_FFFF, 32'd1); tick();
        out_ready = 1'b1; tick();
        chk("b2b_or", result, 32'h0000_F00F);
        tick();
        chk("b2b_slt", result, 32'd1);
        drive(1, 4'd12, 32'd0, 32'd0); tick();
        chk("b2b_nor", result, 32'hFFFF_FFFF);
        drive(0, 4'd0, 32'd0, 32'd0); tick();
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // flush while full with an incoming op
        out_ready = 1'b0;
        drive(1, 4'd2, 32'd1, 32'd2); tick(); tick();
        flush = 1'b1; drive(1, 4'd6, 32'd3, 32'd1); tick();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; drive(0, 4'd0, 32'd0, 32'd0); out_ready = 1'b1; tick(); tick();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // reset while full
        out_ready = 1'b0;
        drive(1, 4'd1, 32'hAAAA_0000, 32'h0000_5555); tick(); tick();
        rst = 1'b1; drive(0, 4'd0, 32'd0, 32'd0); tick();
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_result", result, 32'd0);
        chk("rst2_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        rst = 1'b0;
        #1 chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [31:0] a;
            logic [31:0] b;
            int sel;
            sel = $urandom_range(0, 7);
            op  = (sel < 6) ? ops[sel] : 4'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            drive($urandom_range(0, 3) != 0, op, a, b);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage sitting directly downstream of the ALU control unit: it latches the 4-bit ALU operation code together with two operands, computes the result, and presents it with zero/overflow flags to the memory/writeback side. A 2-entry skid buffer decouples the decode and writeback sides through a valid/ready handshake, so back-pressure never drops or duplicates an operation.

## Interface
- XLEN, 32, operand/result width
- OPW, 4, ALU operation code width (matches the ALU control output)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept; equals ~rst & ~skid_valid
- aluoperation  input  OPW  operation code from ALU control
- op_a  input  XLEN  operand A (rs1)
- op_b  input  XLEN  operand B (rs2 or immediate)
- flush  input  1  discard all buffered and incoming operations
- out_valid  output  1  result entry valid
- out_ready  input  1  downstream accepts result
- result  output  XLEN  computed value
- zero  output  1  result == 0 (branch compare)
- overflow  output  1  signed overflow, ADD/SUB only
- illegal  output  1  unsupported operation code

## Operation
- Codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 0/1); 1100 NOR. Any other code: result 0, zero 1, overflow 0, illegal 1.
- ADD/SUB wrap modulo 2^XLEN; overflow = operand signs match (B inverted for SUB) and result sign differs. Overflow 0 for all other codes.
- Result and flags computed combinationally from inputs, captured at accept (in_valid & in_ready); stored entries never recompute.
- States: EMPTY (no entry), ONE (output reg valid), TWO (output + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & out_ready -> ONE (output reg replaced); accept & ~out_ready -> TWO (new entry into skid); ~accept & out_ready -> EMPTY.
  - TWO: in_ready=0; out_ready -> ONE with skid moved into output reg; else hold.
- Order strictly FIFO; no entry dropped or duplicated except by flush/rst.
- flush: next edge -> EMPTY; an accept in the flush cycle is dropped; in_ready not gated by flush.
- rst dominates flush and handshake.

## Timing
- Latency: accept at edge N -> out_valid high after edge N, i.e., throughout cycle N+1.
- Throughput 1 op/cycle while out_ready held high.
- in_ready depends only on registered state and rst (no combinational path from out_ready).
- out_valid, result, zero, overflow, illegal driven from the output register; stable while out_valid & ~out_ready.
- Reset values: out_valid 0, result 0, zero 0, overflow 0, illegal 0, internal skid_valid 0; in_ready 0 while rst high, 1 first cycle after.
- Reset mid-operation: both entries discarded at the reset edge.

## Structure
- Package alu_pkg: OPW, enum alu_op_e (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), struct alu_resp_t {result, zero, overflow, illegal}; shared with ALU control.
- Sub-module alu_core: purely combinational, (aluoperation, op_a, op_b) -> alu_resp_t.
- alu_exec_stage: state register, output register, skid register, handshake logic.

## Test plan
- Reset then ADD 5+7, out_ready=1 -> result 12, zero 0, overflow 0, out_valid one cycle after accept.
- SUB 0x80000000-1 -> result 0x7FFFFFFF, overflow 1; SUB 9-9 -> result 0, zero 1.
- Back-to-back AND, OR, SLT(-1,1), NOR(0,0) with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts; release yields 0x..., OR result, then 1, then 0xFFFFFFFF in order, none lost.
- Code 0101 -> illegal 1, result 0, zero 1.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid 0, in_ready 1, flushed op never appears.
- rst asserted in state TWO -> all outputs 0 next cycle, in_ready 1 after rst drops.
